// File: rtl/mbldcm_capture_pwm.sv
// PWM capture: synchronises iPwm and measures period and high time in iClock cycles.
// Results appear with a one-cycle oValid strobe pSyncStages+1 clocks after the closing rising edge.
module mbldcm_capture_pwm #(
   parameter int pCounterWidth = 32,
   parameter int pSyncStages   = 2
) (
   input  logic                     iClock,
   input  logic                     iReset_n,
   input  logic                     iPwm,
   input  logic                     iEnable,
   input  logic [pCounterWidth-1:0] iTimeout,
   output logic [pCounterWidth-1:0] oPeriod,
   output logic [pCounterWidth-1:0] oHighTime,
   output logic                     oValid,
   output logic                     oTimeout,
   output logic                     oLevel
);

   localparam logic [pCounterWidth-1:0] CntMax = '1;
   localparam logic [pCounterWidth-1:0] CntOne = {{(pCounterWidth-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {ARM, MEAS_HIGH, MEAS_LOW} state_t;

   state_t                   state_q, state_d;
   logic [pSyncStages-1:0]   sync_q;
   logic                     prev_q;
   logic [pCounterWidth-1:0] cnt_q, cnt_d;
   logic [pCounterWidth-1:0] high_q, high_d;
   logic [pCounterWidth-1:0] period_q, period_d;
   logic [pCounterWidth-1:0] hightime_q, hightime_d;
   logic                     valid_q, valid_d;
   logic                     timeout_q, timeout_d;
   logic                     level, rise, fall, tmo_hit;
   logic [pCounterWidth-1:0] cnt_inc;

   assign level   = sync_q[pSyncStages-1];
   assign rise    = level & ~prev_q;
   assign fall    = ~level & prev_q;
   // Counter sticks at all-ones so an over-long period reads as saturated, never wrapped.
   assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
   // An edge in the same cycle wins over the timeout.
   assign tmo_hit = (iTimeout != '0) && (cnt_q >= iTimeout) && !rise && !fall;

   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         sync_q     <= '0;
         prev_q     <= 1'b0;
         state_q    <= ARM;
         cnt_q      <= '0;
         high_q     <= '0;
         period_q   <= '0;
         hightime_q <= '0;
         valid_q    <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         sync_q     <= {sync_q[pSyncStages-2:0], iPwm};
         prev_q     <= level;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         high_q     <= high_d;
         period_q   <= period_d;
         hightime_q <= hightime_d;
         valid_q    <= valid_d;
         timeout_q  <= timeout_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      high_d     = high_q;
      period_d   = period_q;
      hightime_d = hightime_q;
      valid_d    = 1'b0;
      timeout_d  = timeout_q;
      if (!iEnable) begin
         state_d   = ARM;
         cnt_d     = '0;
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            MEAS_HIGH: begin
               cnt_d = cnt_inc;
               if (fall) begin
                  high_d  = cnt_q;
                  state_d = MEAS_LOW;
               end else if (tmo_hit) begin
                  timeout_d = 1'b1;
                  state_d   = ARM;
                  cnt_d     = '0;
               end
            end
            MEAS_LOW: begin
               cnt_d = cnt_inc;
               if (rise) begin
                  period_d   = cnt_q;
                  hightime_d = high_q;
                  valid_d    = 1'b1;
                  timeout_d  = 1'b0;
                  cnt_d      = CntOne;
                  state_d    = MEAS_HIGH;
               end else if (tmo_hit) begin
                  timeout_d = 1'b1;
                  state_d   = ARM;
                  cnt_d     = '0;
               end
            end
            default: begin
               // First rise only arms; a full period must follow before any result.
               cnt_d = '0;
               if (rise) begin
                  state_d = MEAS_HIGH;
                  cnt_d   = CntOne;
               end
            end
         endcase
      end
   end

   assign oPeriod   = period_q;
   assign oHighTime = hightime_q;
   assign oValid    = valid_q;
   assign oTimeout  = timeout_q;
   assign oLevel    = level;

endmodule

// File: doc/mbldcm_capture_pwm.md
Name: mbldcm_capture_pwm

Overview:
PWM capture/measurement block, the receive-side counterpart of the motor PWM generator. It synchronizes an external PWM input, measures period and high time in iClock cycles, and publishes each completed measurement with a one-cycle valid strobe. A programmable timeout flags a stalled input (0 % or 100 % duty). It is used for command-PWM inputs and for loop-back checking of generated PWM.

Parameters:
pCounterWidth, 32, width of the measurement counter and of the period/high-time outputs.
pSyncStages, 2, number of input synchronizer flops (minimum 2).

Ports:
iClock  input  1  system clock.
iReset_n  input  1  reset, asynchronous, active-low.
iPwm  input  1  asynchronous PWM input.
iEnable  input  1  capture enable; low forces the ARM state.
iTimeout  input  pCounterWidth  timeout threshold in cycles; 0 disables the timeout.
oPeriod  output  pCounterWidth  last measured period in cycles (rising edge to rising edge).
oHighTime  output  pCounterWidth  last measured high time in cycles (rising edge to falling edge).
oValid  output  1  one-cycle strobe; oPeriod and oHighTime were updated on this cycle.
oTimeout  output  1  sticky flag; no edge within iTimeout cycles.
oLevel  output  1  synchronized input level.

Behaviour:
- Reset (asynchronous, iReset_n=0): synchronizer flops = 0, previous-level flop = 0, state = ARM, rCnt = 0, rHigh = 0, oPeriod = 0, oHighTime = 0, oValid = 0, oTimeout = 0. oLevel is therefore 0.
- Synchronizer: iPwm passes through pSyncStages flops. oLevel is the last stage. rPrev holds oLevel delayed one cycle.
- Edge detection: rise = oLevel & ~rPrev; fall = ~oLevel & rPrev. These are combinational and evaluated in the same cycle.
- States: ARM, MEAS_HIGH, MEAS_LOW.
  - ARM: rCnt is held at 0. On rise, go to MEAS_HIGH with rCnt <= 1. A fall is ignored.
  - MEAS_HIGH: rCnt increments each cycle. On fall, rHigh <= rCnt, rCnt <= rCnt+1, go to MEAS_LOW.
  - MEAS_LOW: rCnt increments. On rise: oPeriod <= rCnt, oHighTime <= rHigh, oValid <= 1, oTimeout <= 0, rCnt <= 1, go to MEAS_HIGH.
- Counting result: with rises P cycles apart and high for H cycles, oPeriod = P and oHighTime = H exactly.
- The first rise after reset, enable, or timeout only arms the measurement. No oValid is produced until a full period has been seen.
- Latency: a transition on iPwm reaches oValid after pSyncStages+1 clocks, provided it completes a period.
- oValid is high for exactly one cycle per completed period and low otherwise.
- Saturation: rCnt saturates at all-ones and never wraps. A saturated period is reported as the all-ones value.
- Timeout: active in MEAS_HIGH or MEAS_LOW when iTimeout != 0 and rCnt >= iTimeout and no edge occurs this cycle. Action: oTimeout <= 1, state <= ARM, rCnt <= 0. oPeriod and oHighTime hold their values.
  - An edge in the same cycle as the timeout condition takes priority; the timeout does not fire.
  - Software reads oLevel to distinguish 0 % from 100 % duty.
- oTimeout clears on the next oValid or while iEnable = 0.
- iEnable = 0 has priority over everything except reset: state = ARM, rCnt = 0, oValid = 0, oTimeout = 0. oPeriod and oHighTime hold. The synchronizer keeps running.
- Changing iTimeout takes effect on the next cycle's comparison.
- Reset mid-measurement: immediate return to reset values. Synchronizer history is discarded, so a high iPwm at reset release appears as a rise after pSyncStages cycles (arm only).

Test Plan:
1. iEnable=1, iTimeout=0, iPwm period 100 clocks, high 30 clocks, 3 periods -> first rise arms only; then oValid pulses every 100 clocks with oPeriod=100, oHighTime=30; oValid is 1 cycle wide.
2. Duty change mid-stream from high 30 to high 70 (period 100) -> the next oValid reports oHighTime=70 and oPeriod=100; no missing or extra oValid.
3. iTimeout=500, iPwm held high after a rise -> oTimeout=1 when rCnt reaches 500, state ARM, oLevel=1, oPeriod/oHighTime unchanged. Restarting PWM -> oTimeout clears at the first oValid, one full period after re-arm.
4. iEnable dropped mid-MEAS_LOW, then raised -> no oValid while low; after re-enable, the first rise arms only and the second rise gives oValid with the correct period.
5. pCounterWidth=8, iTimeout=0, period 300 clocks high 100 -> oPeriod=255 (saturated), oHighTime=100.
6. Assert iReset_n asynchronously between clock edges mid-MEAS_HIGH -> all outputs reach reset values before the next iClock edge; after release, a steady-high iPwm produces no oValid until a complete period.
